// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the signals between the MEM stage, the memory access unit and the
// byte-addressed data memory.
//   Request  : req_valid, req_ready, req_op[2:0], req_addr[15:0], req_wdata[15:0]
//   Response : resp_valid, resp_rdata[15:0], resp_err
//   Memory   : mem_wr_en, mem_rd_en, mem_nbytes[1:0], mem_addr[15:0],
//              mem_wdata[15:0], mem_rdata[15:0]
// The slave modport is the unit itself; the master modport is its environment
// (pipeline requester plus data memory).
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [1:0]  mem_nbytes;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_wr_en, mem_rd_en, mem_nbytes, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_wr_en, mem_rd_en, mem_nbytes, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit for a 16-bit byte-addressed data memory.
// Supports LW, LBU, LBS, SW and SB (SB is done as read-modify-write of the
// containing 16-bit word). Illegal opcodes and word accesses at 0xFFFF are
// answered with an error response and never touch memory.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous reset, active low
//   bus   - mem_access_unit_if.slave (request, response and memory signals)
// -----------------------------------------------------------------------------
module mem_access_unit (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LBS = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [7:0]  wbyte_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [1:0]  mem_nbytes_q;
  logic [15:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        illegal;
  logic [1:0]  nbytes_sel;

  // Request qualification: a request is taken only in IDLE. Word accesses at
  // 0xFFFF would need byte 0x10000, which does not exist, so they are errors.
  always_comb begin
    accept  = bus.req_valid && (state_q == IDLE);
    illegal = (bus.req_op > OP_SB) ||
              (((bus.req_op == OP_LW) || (bus.req_op == OP_SW) ||
                (bus.req_op == OP_SB)) && (bus.req_addr == 16'hFFFF));
  end

  // Width/extension code sent to memory. SB reads and writes a whole word.
  always_comb begin
    nbytes_sel = 2'b00;
    case (bus.req_op)
      OP_LBU:  nbytes_sel = 2'b01;
      OP_LBS:  nbytes_sel = 2'b10;
      default: nbytes_sel = 2'b00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Loads and SB go through RD/CAP; SB then continues to WR
  // to write the merged word back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d = RESP;
          end else if (bus.req_op == OP_SW) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = (op_q == OP_SB) ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: strobes and handshakes are pure functions of the state,
  // so each strobe lasts exactly the one cycle spent in RD or WR.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.mem_rd_en  = (state_q == RD);
    bus.mem_wr_en  = (state_q == WR);
  end

  // Datapath registers. Memory address/data/width are loaded only when a new
  // access starts (or, for SB, when the merged word is formed), so they hold
  // their last values while no strobe is active. Response data/err are loaded
  // on the edge entering RESP and then held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_LW;
      wbyte_q      <= 8'h00;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      mem_nbytes_q <= 2'b00;
      resp_rdata_q <= 16'h0000;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept && !illegal) begin
        op_q         <= bus.req_op;
        wbyte_q      <= bus.req_wdata[7:0];
        mem_addr_q   <= bus.req_addr;
        mem_nbytes_q <= nbytes_sel;
        if (bus.req_op == OP_SW) begin
          mem_wdata_q <= bus.req_wdata;
        end
      end
      if (accept && illegal) begin
        resp_rdata_q <= 16'h0000;
        resp_err_q   <= 1'b1;
      end
      if (state_q == CAP) begin
        if (op_q == OP_SB) begin
          // Keep the upper byte read from memory, replace the addressed byte.
          mem_wdata_q <= {bus.mem_rdata[15:8], wbyte_q};
        end else begin
          resp_rdata_q <= bus.mem_rdata;
          resp_err_q   <= 1'b0;
        end
      end
      if (state_q == WR) begin
        resp_rdata_q <= 16'h0000;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_nbytes = mem_nbytes_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Drives load/store requests into mem_access_unit, models a byte-addressed
// data memory, and compares every response against expectations queued when
// the request was issued.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk;
  logic rst_n;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acceptCycle;
    int          lat;
    int          nRd;
    int          nWr;
    logic [1:0]  nbytes;
    logic [15:0] addr;
    logic [15:0] wdata;
  } expect_t;

  expect_t     sbQ[$];
  logic [7:0]  mem [0:65535];
  int          cycle;
  int          assertCount;
  int          failCount;
  int          rdCnt;
  int          wrCnt;
  logic [1:0]  lastNb;
  logic [15:0] lastAddr;
  logic [15:0] lastWd;

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure response latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Data memory model: reads return data the cycle after mem_rd_en, already
  // extended according to mem_nbytes; word writes store low byte at addr.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      case (bus.mem_nbytes)
        2'b01:   bus.mem_rdata <= {8'h00, mem[bus.mem_addr]};
        2'b10:   bus.mem_rdata <= {{8{mem[bus.mem_addr][7]}}, mem[bus.mem_addr]};
        default: bus.mem_rdata <= {mem[bus.mem_addr + 16'd1], mem[bus.mem_addr]};
      endcase
    end
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wdata[7:0];
      if (bus.mem_nbytes == 2'b00) mem[bus.mem_addr + 16'd1] <= bus.mem_wdata[15:8];
    end
  end

  // Monitor: tracks strobes between responses and checks each response
  // against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("strobe_overlap", {31'd0, bus.mem_rd_en & bus.mem_wr_en}, 32'd0);
      if (bus.mem_rd_en) begin
        rdCnt++;
        lastNb   = bus.mem_nbytes;
        lastAddr = bus.mem_addr;
      end
      if (bus.mem_wr_en) begin
        wrCnt++;
        lastWd   = bus.mem_wdata;
        lastAddr = bus.mem_addr;
        checkOutput("wr_nbytes", {30'd0, bus.mem_nbytes}, 32'd0);
      end
      if (bus.resp_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("resp_without_request", {31'd0, bus.resp_valid}, 32'd0);
        end else begin
          expect_t e;
          e = sbQ.pop_front();
          checkOutput("resp_rdata", {16'd0, bus.resp_rdata}, {16'd0, e.rdata});
          checkOutput("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          checkOutput("resp_latency", cycle - e.acceptCycle, e.lat);
          checkOutput("rd_strobes", rdCnt, e.nRd);
          checkOutput("wr_strobes", wrCnt, e.nWr);
          if (e.nRd > 0) checkOutput("rd_nbytes", {30'd0, lastNb}, {30'd0, e.nbytes});
          if (e.nRd + e.nWr > 0) checkOutput("mem_addr", {16'd0, lastAddr}, {16'd0, e.addr});
          if (e.nWr > 0) checkOutput("mem_wdata", {16'd0, lastWd}, {16'd0, e.wdata});
        end
        rdCnt = 0;
        wrCnt = 0;
      end
    end
  end

  // Issue one request, queue its expectation and wait for acceptance.
  // Inputs are scrambled after acceptance so latching is exercised.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr,
                               input logic [15:0] wdata, input bit keepValid,
                               input logic [15:0] expRdata, input logic expErr,
                               input int expLat, input int expRd, input int expWr,
                               input logic [1:0] expNb, input logic [15:0] expWd);
    expect_t e;
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {31'd0, bus.req_ready}, 32'd1);
    e.rdata = expRdata; e.err = expErr; e.acceptCycle = cycle; e.lat = expLat;
    e.nRd = expRd; e.nWr = expWr; e.nbytes = expNb; e.addr = addr; e.wdata = expWd;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (!keepValid) begin
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b110;
      bus.req_addr  = ~addr;
      bus.req_wdata = ~wdata;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain_pending", sbQ.size(), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"},  {31'd0, bus.req_ready},  32'd1);
    checkOutput({tag, "_valid"},  {31'd0, bus.resp_valid}, 32'd0);
    checkOutput({tag, "_rdata"},  {16'd0, bus.resp_rdata}, 32'd0);
    checkOutput({tag, "_err"},    {31'd0, bus.resp_err},   32'd0);
    checkOutput({tag, "_rd_en"},  {31'd0, bus.mem_rd_en},  32'd0);
    checkOutput({tag, "_wr_en"},  {31'd0, bus.mem_wr_en},  32'd0);
    checkOutput({tag, "_nbytes"}, {30'd0, bus.mem_nbytes}, 32'd0);
    checkOutput({tag, "_addr"},   {16'd0, bus.mem_addr},   32'd0);
    checkOutput({tag, "_wdata"},  {16'd0, bus.mem_wdata},  32'd0);
  endtask

  initial begin
    cycle = 0; assertCount = 0; failCount = 0;
    rdCnt = 0; wrCnt = 0; lastNb = 2'b00; lastAddr = 16'h0; lastWd = 16'h0;
    bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_addr = 16'h0;
    bus.req_wdata = 16'h0; bus.mem_rdata = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h92;
    mem[16'h0013] = 8'h78; mem[16'h0014] = 8'h56;
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;
    mem[16'hFFFF] = 8'h80;

    rst_n = 1'b0;
    #23;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Loads of each width, then SB read-modify-write and readback.
    applyStimulus(3'b000, 16'h0010, 16'h0000, 0, 16'h9234, 0, 3, 1, 0, 2'b00, 16'h0);
    applyStimulus(3'b010, 16'h0011, 16'h0000, 0, 16'hFF92, 0, 3, 1, 0, 2'b10, 16'h0);
    applyStimulus(3'b001, 16'h0011, 16'h0000, 0, 16'h0092, 0, 3, 1, 0, 2'b01, 16'h0);
    applyStimulus(3'b100, 16'h0010, 16'hABCD, 0, 16'h0000, 0, 4, 1, 1, 2'b00, 16'h92CD);
    applyStimulus(3'b000, 16'h0010, 16'h0000, 0, 16'h92CD, 0, 3, 1, 0, 2'b00, 16'h0);
    // Rejected requests: word store at top of space, illegal opcode.
    applyStimulus(3'b011, 16'hFFFF, 16'h1234, 0, 16'h0000, 1, 1, 0, 0, 2'b00, 16'h0);
    applyStimulus(3'b111, 16'h0010, 16'h1234, 0, 16'h0000, 1, 1, 0, 0, 2'b00, 16'h0);
    // Byte load at 0xFFFF is legal.
    applyStimulus(3'b010, 16'hFFFF, 16'h0000, 0, 16'hFF80, 0, 3, 1, 0, 2'b10, 16'h0);
    // Back-to-back with req_valid held: odd-address LW then SW.
    applyStimulus(3'b000, 16'h0013, 16'h0000, 1, 16'h5678, 0, 3, 1, 0, 2'b00, 16'h0);
    applyStimulus(3'b011, 16'h0030, 16'hBEEF, 0, 16'h0000, 0, 2, 0, 1, 2'b00, 16'hBEEF);
    applyStimulus(3'b000, 16'h0030, 16'h0000, 0, 16'hBEEF, 0, 3, 1, 0, 2'b00, 16'h0);
    waitDrain();

    // Reset during SB CAP: abandoned, no write, no response.
    applyStimulus(3'b100, 16'h0020, 16'h5555, 0, 16'h0000, 0, 4, 1, 1, 2'b00, 16'h2255);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    void'(sbQ.pop_back());
    rdCnt = 0;
    wrCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midreset_no_strobe", rdCnt + wrCnt, 32'd0);
    checkOutput("midreset_mem20", {24'd0, mem[16'h0020]}, 32'h11);
    checkOutput("midreset_mem21", {24'd0, mem[16'h0021]}, 32'h22);
    applyStimulus(3'b000, 16'h0020, 16'h0000, 0, 16'h2211, 0, 3, 1, 0, 2'b00, 16'h0);
    waitDrain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
